// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic path.
// Sequencer states and default datapath width.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder shared by the serial sequencer.
// Pure combinational sum/carry.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  // sum and carry of three input bits
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer, LSB first.
// One full adder reused for WIDTH cycles per operation.
module serial_adder_ctrl
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last;

  full_adder u_fa (
    .a     (sh_a[0]),
    .b     (sh_b[0]),
    .c     (cy),
    .sum   (fa_s),
    .carry (fa_c)
  );

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign accept  = req_valid && req_ready;
  assign last    = (state == RUN) && (cnt == LAST);
  assign res_nxt = WIDTH'({fa_s, res} >> 1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: accept, WIDTH bit steps, wait for consumer
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req_valid)      state_nxt = RUN;
      RUN:  if (cnt == LAST)    state_nxt = DONE;
      DONE: if (rsp_ready)      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // operand shifters, carry, bit counter, partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a <= '0;
      sh_b <= '0;
      res  <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      sh_a <= req_a;
      sh_b <= req_sub ? ~req_b : req_b;
      res  <= '0;
      cy   <= req_sub;
      cnt  <= '0;
    end else if (state == RUN) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      res  <= res_nxt;
      cy   <= fa_c;
      cnt  <= cnt + 1'b1;
    end
  end

  // response registers load on the MSB step and hold afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else if (last) begin
      rsp_sum  <= res_nxt;
      rsp_cout <= fa_c;
      rsp_ovf  <= cy ^ fa_c;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8).
// Stimulus pushes expectations; a monitor pops on response handshakes.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         req_sub = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_ovf;
  logic         busy;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rdy_pct = 100;
  int   bp_hold = 0;
  int   max_gap = 0;
  bit   new_rsp = 1'b1;
  bit   chk_idle = 1'b0;
  exp_t q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  // reference: signed/unsigned integer arithmetic
  function automatic exp_t model(logic [W-1:0] a,
                                 logic [W-1:0] b,
                                 logic sub);
    exp_t e;
    int sa;
    int sb;
    int r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r   = sa - sb;
      e.c = (a >= b);
      e.s = W'(int'(a) - int'(b));
    end else begin
      r   = sa + sb;
      e.c = (int'(a) + int'(b)) > 255;
      e.s = W'(int'(a) + int'(b));
    end
    e.o   = (r > 127) || (r < -128);
    e.acc = 0;
    return e;
  endfunction

  // one cycle with no real request; junk while busy
  task automatic idle_cycle();
    @(negedge clk);
    if (!req_ready) begin
      req_valid = 1'($urandom);
      req_a     = W'($urandom);
      req_b     = W'($urandom);
      req_sub   = 1'($urandom);
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b,
                      logic sub, exp_t e, bit push);
    int n;
    n = 0;
    repeat ($urandom_range(0, max_gap)) idle_cycle();
    forever begin
      @(negedge clk);
      if (req_ready) begin
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        e.acc     = cyc + 1;
        if (push) q.push_back(e);
        break;
      end
      req_valid = 1'($urandom);
      req_a     = W'($urandom);
      req_b     = W'($urandom);
      n++;
      if (n > 1000) begin
        chk("accept_timeout", 32'd1, 32'd0);
        return;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      idle_cycle();
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    repeat (2) idle_cycle();
  endtask

  // monitor: pops expectation on each response handshake
  initial begin : monitor
    logic [W-1:0] h_s;
    logic         h_c;
    logic         h_o;
    bit           rdy;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rsp_ready = 1'b0;
        new_rsp   = 1'b1;
        chk_idle  = 1'b0;
        continue;
      end
      if (chk_idle) begin
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_valid", 32'(rsp_valid), 32'd0);
        chk_idle = 1'b0;
      end
      if (rsp_valid) begin
        chk("done_ready", 32'(req_ready), 32'd0);
        if (new_rsp) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            chk("latency", 32'(cyc - q[0].acc), 32'(W));
          end
          h_s     = rsp_sum;
          h_c     = rsp_cout;
          h_o     = rsp_ovf;
          new_rsp = 1'b0;
        end else begin
          chk("stable", {rsp_sum, rsp_cout, rsp_ovf},
              {h_s, h_c, h_o});
        end
        if (bp_hold > 0) begin
          rdy = 1'b0;
          bp_hold--;
        end else begin
          rdy = ($urandom_range(0, 99) < rdy_pct);
        end
        rsp_ready = rdy;
        if (rdy) begin
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("sum", 32'(rsp_sum), 32'(e.s));
            chk("cout", 32'(rsp_cout), 32'(e.c));
            chk("ovf", 32'(rsp_ovf), 32'(e.o));
          end
          new_rsp  = 1'b1;
          chk_idle = 1'b1;
        end
      end else begin
        rsp_ready = 1'($urandom);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [W-1:0] da[6];
    logic [W-1:0] db[6];
    logic         dsub[6];
    logic [W-1:0] ds[6];
    logic         dc[6];
    logic         dov[6];
    exp_t         e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;

    da   = '{8'h05, 8'hFF, 8'h7F, 8'h80, 8'h05, 8'h80};
    db   = '{8'h03, 8'h01, 8'h01, 8'h80, 8'h07, 8'h01};
    dsub = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ds   = '{8'h08, 8'h00, 8'h80, 8'h00, 8'hFE, 8'h7F};
    dc   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    dov  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", {rsp_sum, rsp_cout, rsp_ovf}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    rdy_pct = 100;
    for (int i = 0; i < 6; i++) begin
      e.s = ds[i];
      e.c = dc[i];
      e.o = dov[i];
      send(da[i], db[i], dsub[i], e, 1'b1);
    end
    drain();

    bp_hold = 5;
    e = model(8'h3C, 8'h5A, 1'b1);
    send(8'h3C, 8'h5A, 1'b1, e, 1'b1);
    drain();
    chk("bp_consumed", 32'(bp_hold), 32'd0);

    e = model(8'h11, 8'h22, 1'b0);
    send(8'h11, 8'h22, 1'b0, e, 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    chk("arst_outs", {rsp_sum, rsp_cout, rsp_ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e.s = 8'h30;
    e.c = 1'b0;
    e.o = 1'b0;
    send(8'h10, 8'h20, 1'b0, e, 1'b1);
    drain();

    rdy_pct = 60;
    max_gap = 3;
    for (int i = 0; i < 256; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom);
      send(a, b, s, model(a, b, s), 1'b1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
